// File: rtl/apb_pkg.sv
// Shared APB types: requester FSM states, slave decode window and latched request.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package apb_pkg;

   localparam int APB_ADDR_W = 32;
   localparam int APB_DATA_W = 32;

   // Base of the single APB slave; the window is 2**APB_WIN_BITS bytes.
   localparam logic [APB_ADDR_W-1:0] SLAVE_ADDR   = 32'h0000_A000;
   localparam int                    APB_WIN_BITS = 12;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_t;

   // Request captured on accept; drives paddr/pwrite/pwdata directly.
   typedef struct packed {
      logic                  write;
      logic [APB_ADDR_W-1:0] addr;
      logic [APB_DATA_W-1:0] wdata;
   } apb_req_t;

endpackage

// File: rtl/apb_master_ctrl.sv
// APB requester: one valid/ready request in, one APB transfer out, one response pulse back.
// Latency: hit = 3 cycles + pready wait states; decode miss = 1 cycle (error response).
// Backpressure: req_ready low while a transfer is outstanding; rsp_valid cannot be stalled.
//
// Ports:
//   pclk, preset_n                      clock, asynchronous active-low reset
//   req_valid/req_ready                 request handshake
//   req_write, req_addr, req_wdata      request payload
//   rsp_valid, rsp_rdata, rsp_err       one-cycle response (rdata 0 for writes/errors)
//   psel, penable, pwrite, paddr, pwdata  APB requester outputs (all registered)
//   prdata, pready                      APB slave return
//
// Build option: APB_TIMEOUT_EN adds an ACCESS-phase wait limit of TIMEOUT_CYC cycles,
// after which the transfer is abandoned with rsp_err=1. Without it ACCESS waits forever.
module apb_master_ctrl
   import apb_pkg::*;
#(
   parameter int ADDR_W      = APB_ADDR_W,
   parameter int DATA_W      = APB_DATA_W,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              pclk,
   input  logic              preset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              psel,
   output logic              penable,
   output logic              pwrite,
   output logic [ADDR_W-1:0] paddr,
   output logic [DATA_W-1:0] pwdata,
   input  logic [DATA_W-1:0] prdata,
   input  logic              pready
);

   apb_state_t        state, state_nxt;
   apb_req_t          req_q, req_nxt;
   logic              psel_nxt, penable_nxt, ready_nxt;
   logic              rsp_valid_nxt, rsp_err_nxt;
   logic [DATA_W-1:0] rsp_rdata_nxt;
   logic              dec_hit;

   // Only the bits above the window are compared; the low bits select inside the slave.
   assign dec_hit = (req_addr[ADDR_W-1:APB_WIN_BITS] == SLAVE_ADDR[ADDR_W-1:APB_WIN_BITS]);

`ifdef APB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] to_cnt, to_cnt_nxt, to_cnt_inc;
   assign to_cnt_inc = to_cnt + 1'b1;
`endif

   // Next-state and next-output logic.
   always_comb begin
      state_nxt     = state;
      req_nxt       = req_q;
      psel_nxt      = psel;
      penable_nxt   = penable;
      ready_nxt     = 1'b0;
      rsp_valid_nxt = 1'b0;
      rsp_err_nxt   = 1'b0;
      rsp_rdata_nxt = '0;
`ifdef APB_TIMEOUT_EN
      to_cnt_nxt    = to_cnt;
`endif
      case (state)
         ST_IDLE: begin
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
            ready_nxt   = 1'b1;
            if (req_valid && req_ready) begin
               ready_nxt = 1'b0;
               if (dec_hit) begin
                  // Only hits update the bus payload, so paddr keeps the last real transfer.
                  req_nxt   = '{write: req_write, addr: req_addr, wdata: req_wdata};
                  psel_nxt  = 1'b1;
                  state_nxt = ST_SETUP;
               end else begin
                  rsp_valid_nxt = 1'b1;
                  rsp_err_nxt   = 1'b1;
               end
            end
         end
         ST_SETUP: begin
            penable_nxt = 1'b1;
            state_nxt   = ST_ACCESS;
`ifdef APB_TIMEOUT_EN
            to_cnt_nxt  = '0;
`endif
         end
         ST_ACCESS: begin
            if (pready) begin
               psel_nxt      = 1'b0;
               penable_nxt   = 1'b0;
               ready_nxt     = 1'b1;
               rsp_valid_nxt = 1'b1;
               rsp_rdata_nxt = req_q.write ? '0 : prdata;
               state_nxt     = ST_IDLE;
            end
`ifdef APB_TIMEOUT_EN
            // pready on the limit cycle is handled above and wins over the timeout.
            else if (to_cnt_inc == CNT_W'(TIMEOUT_CYC)) begin
               psel_nxt      = 1'b0;
               penable_nxt   = 1'b0;
               ready_nxt     = 1'b1;
               rsp_valid_nxt = 1'b1;
               rsp_err_nxt   = 1'b1;
               state_nxt     = ST_IDLE;
            end else begin
               to_cnt_nxt = to_cnt_inc;
            end
`endif
         end
         default: begin
            state_nxt   = ST_IDLE;
            psel_nxt    = 1'b0;
            penable_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         req_q     <= '0;
         psel      <= 1'b0;
         penable   <= 1'b0;
         req_ready <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         req_q     <= req_nxt;
         psel      <= psel_nxt;
         penable   <= penable_nxt;
         req_ready <= ready_nxt;
         rsp_valid <= rsp_valid_nxt;
         rsp_err   <= rsp_err_nxt;
         rsp_rdata <= rsp_rdata_nxt;
      end
   end

`ifdef APB_TIMEOUT_EN
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         to_cnt <= '0;
      end else begin
         to_cnt <= to_cnt_nxt;
      end
   end
`endif

   assign pwrite = req_q.write;
   assign paddr  = req_q.addr;
   assign pwdata = req_q.wdata;

endmodule
